// File: rtl/ps2_arrow_decoder_pkg.sv
// ps2_arrow_pkg: shared types and constants for the PS/2 arrow-key decoder.
//   - dir_t      : 2-bit direction reported on move_dir
//   - held_t     : direction currently held down, with a "none" encoding
//   - rx_state_t : receiver frame state
//   - SC_*       : scan-code constants (prefixes, arrows, WASD)
// The optional WASD decode is controlled by the PS2_ARROW_WASD_EN macro in
// ps2_arrow_decoder.sv; this package only provides the codes.
package ps2_arrow_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Bit 2 set means no direction is held; bits [1:0] mirror dir_t otherwise.
  typedef enum logic [2:0] {
    HELD_UP    = 3'd0,
    HELD_DOWN  = 3'd1,
    HELD_LEFT  = 3'd2,
    HELD_RIGHT = 3'd3,
    HELD_NONE  = 3'd4
  } held_t;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_arrow_decoder_rx_frame.sv
// ps2_rx_frame: PS/2 frame receiver.
//   Synchronises PS2_CLK/PS2_DAT, glitch-filters the clock, strobes on its
//   falling edge and deserialises 11-bit frames (start, 8 data LSB first,
//   odd parity, stop). A stalled frame is aborted after TIMEOUT_CYC cycles.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   PS2_CLK, PS2_DAT    : raw asynchronous keyboard lines
//   rx_byte, rx_valid   : received byte and its one-cycle valid pulse
//   err_parity          : one-cycle pulse on a parity error
//   err_frame           : one-cycle pulse on bad start/stop bit or timeout
module ps2_rx_frame
  import ps2_arrow_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       err_parity,
  output logic       err_frame
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_filt, r_filt_d;
  logic [FCW-1:0]  r_fcnt;
  logic            w_strobe;
  rx_state_t       r_state, w_state_nx;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [TCW-1:0]  r_to_cnt;
  logic            w_timeout;
  logic            w_valid_nx, w_perr_nx, w_ferr_nx;
  logic            r_rx_valid, r_err_parity, r_err_frame;

  // Two-flop synchronisers; idle PS/2 lines are high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= PS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= PS2_DAT;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Clock filter: flip only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_s2 != r_filt) begin
        if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
          r_filt <= r_clk_s2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + FCW'(1);
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  assign w_strobe  = r_filt_d & ~r_filt;
  assign w_timeout = (r_state != RX_IDLE) && !w_strobe &&
                     (r_to_cnt == TCW'(TIMEOUT_CYC - 1));

  // Receiver state register plus registered result pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RX_IDLE;
      r_rx_valid   <= 1'b0;
      r_err_parity <= 1'b0;
      r_err_frame  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_rx_valid   <= w_valid_nx;
      r_err_parity <= w_perr_nx;
      r_err_frame  <= w_ferr_nx;
    end
  end

  // Receiver next-state logic; a timeout overrides everything.
  always_comb begin
    w_state_nx = r_state;
    if (w_timeout) begin
      w_state_nx = RX_IDLE;
    end else if (w_strobe) begin
      case (r_state)
        RX_IDLE:   w_state_nx = r_dat_s2 ? RX_IDLE : RX_DATA;
        RX_DATA:   w_state_nx = (r_bitcnt == 3'd7) ? RX_PARITY : RX_DATA;
        RX_PARITY: w_state_nx = RX_STOP;
        RX_STOP:   w_state_nx = RX_IDLE;
        default:   w_state_nx = RX_IDLE;
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

  // Receiver result decode, registered above.
  always_comb begin
    w_valid_nx = 1'b0;
    w_perr_nx  = 1'b0;
    w_ferr_nx  = w_timeout;
    if (w_strobe) begin
      case (r_state)
        RX_IDLE: w_ferr_nx = r_dat_s2;
        RX_STOP: begin
          if (!odd_parity_ok(r_shift, r_par)) begin
            w_perr_nx = 1'b1;
          end else if (!r_dat_s2) begin
            w_ferr_nx = 1'b1;
          end else begin
            w_valid_nx = 1'b1;
          end
        end
        default: w_valid_nx = 1'b0;
      endcase
    end else begin
      w_valid_nx = 1'b0;
    end
  end

  // Shift register, bit counter, parity capture and inter-strobe timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitcnt <= 3'd0;
      r_shift  <= 8'd0;
      r_par    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      if (r_state == RX_IDLE || w_strobe) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TCW'(1);
      end
      if (w_strobe) begin
        case (r_state)
          RX_IDLE:   r_bitcnt <= 3'd0;
          RX_DATA: begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          RX_PARITY: r_par <= r_dat_s2;
          default:   r_bitcnt <= 3'd0;
        endcase
      end
    end
  end

  assign rx_byte    = r_shift;
  assign rx_valid   = r_rx_valid;
  assign err_parity = r_err_parity;
  assign err_frame  = r_err_frame;

endmodule

// File: rtl/ps2_arrow_decoder.sv
// ps2_arrow_decoder: PS/2 keyboard to direction-event front end.
//   Tracks E0/F0 prefixes, keeps the currently held direction, suppresses
//   typematic repeats and presents one event per key press through a 1-deep
//   valid/ready output register.
//   Define PS2_ARROW_WASD_EN to also decode unprefixed W/S/A/D keys.
// Ports:
//   clk, reset           : system clock, synchronous active-high reset
//   PS2_CLK, PS2_DAT     : raw asynchronous keyboard lines
//   move_valid/move_dir  : direction event (0 up, 1 down, 2 left, 3 right)
//   move_ready           : consumer accepts on move_valid & move_ready
//   err_parity/err_frame : one-cycle receive error pulses
//   overflow             : sticky, an event was dropped
module ps2_arrow_decoder
  import ps2_arrow_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow
);

  logic [7:0] w_rx_byte;
  logic       w_rx_valid, w_err_par, w_err_frm;
  logic       r_ext, r_brk;
  held_t      r_held;
  logic       w_is_prefix, w_is_dir, w_evt;
  dir_t       w_dir;
  logic       r_move_valid, r_overflow;
  dir_t       r_move_dir;

  ps2_rx_frame #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .rx_byte    (w_rx_byte),
    .rx_valid   (w_rx_valid),
    .err_parity (w_err_par),
    .err_frame  (w_err_frm)
  );

  assign w_is_prefix = (w_rx_byte == SC_EXT) || (w_rx_byte == SC_BRK);

  // Classify the received byte against the current extended flag.
  always_comb begin
    w_is_dir = 1'b0;
    w_dir    = DIR_UP;
    if (r_ext) begin
      case (w_rx_byte)
        SC_UP:    begin w_is_dir = 1'b1; w_dir = DIR_UP;    end
        SC_DOWN:  begin w_is_dir = 1'b1; w_dir = DIR_DOWN;  end
        SC_LEFT:  begin w_is_dir = 1'b1; w_dir = DIR_LEFT;  end
        SC_RIGHT: begin w_is_dir = 1'b1; w_dir = DIR_RIGHT; end
        default:  begin w_is_dir = 1'b0; w_dir = DIR_UP;    end
      endcase
    end else begin
`ifdef PS2_ARROW_WASD_EN
      case (w_rx_byte)
        SC_W:    begin w_is_dir = 1'b1; w_dir = DIR_UP;    end
        SC_S:    begin w_is_dir = 1'b1; w_dir = DIR_DOWN;  end
        SC_A:    begin w_is_dir = 1'b1; w_dir = DIR_LEFT;  end
        SC_D:    begin w_is_dir = 1'b1; w_dir = DIR_RIGHT; end
        default: begin w_is_dir = 1'b0; w_dir = DIR_UP;    end
      endcase
`else
      w_is_dir = 1'b0;
`endif
    end
  end

  // A make of a direction other than the one held is a new press.
  assign w_evt = w_rx_valid && !w_is_prefix && w_is_dir && !r_brk &&
                 (r_held != held_t'({1'b0, w_dir}));

  // Prefix flags: set by E0/F0, consumed by the next code, cleared by errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_err_par || w_err_frm) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_rx_valid) begin
      if (w_rx_byte == SC_EXT) begin
        r_ext <= 1'b1;
      end else if (w_rx_byte == SC_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  // Held direction: updated on makes even when the event itself is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_held <= HELD_NONE;
    end else if (w_rx_valid && !w_is_prefix && w_is_dir) begin
      if (!r_brk) begin
        r_held <= held_t'({1'b0, w_dir});
      end else if (r_held == held_t'({1'b0, w_dir})) begin
        r_held <= HELD_NONE;
      end
    end
  end

  // 1-deep output register; may reload in the cycle its event is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_move_valid <= 1'b0;
      r_move_dir   <= DIR_UP;
      r_overflow   <= 1'b0;
    end else if (w_evt) begin
      if (!r_move_valid || move_ready) begin
        r_move_valid <= 1'b1;
        r_move_dir   <= w_dir;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (r_move_valid && move_ready) begin
      r_move_valid <= 1'b0;
    end
  end

  assign move_valid = r_move_valid;
  assign move_dir   = r_move_dir;
  assign overflow   = r_overflow;
  assign err_parity = w_err_par;
  assign err_frame  = w_err_frm;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
module tb_ps2_arrow_decoder;

  localparam int TO_CYC = 2000;
  localparam int HALF   = 25;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready = 1'b1;
  logic       err_parity, err_frame, overflow;

  int n_checks = 0;
  int n_errors = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int evt_cyc = 0;
  logic [1:0] exp_q[$];

  ps2_arrow_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (move_ready),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected direction on every accepted event, counts error pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (err_parity) n_perr++;
      if (err_frame) n_ferr++;
      if (move_valid && move_ready) begin
        evt_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_event: got dir %0d expected no event", move_dir);
        end else begin
          check("move_dir", int'(move_dir), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    PS2_DAT = b;
    idle(HALF);
    PS2_CLK = 1'b0;
    stop_cyc = cyc;
    idle(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic flip_par, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ flip_par);
    send_bit(stop_b);
    PS2_DAT = 1'b1;
    idle(30);
  endtask

  task automatic send(input logic [7:0] d);
    send_byte(d, 1'b0, 1'b1);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int perr0, ferr0;
    idle(4);
    check("rst_move_valid", int'(move_valid), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_err_parity", int'(err_parity), 0);
    check("rst_err_frame", int'(err_frame), 0);
    reset = 1'b0;
    idle(5);

    // Single arrow press with latency check.
    exp_q.push_back(2'd0);
    send(8'hE0); send(8'h75);
    drain("up_drain");
    check("up_latency_ok", int'((evt_cyc - stop_cyc) >= 10 && (evt_cyc - stop_cyc) <= 14), 1);
    check("up_err_cnt", n_perr + n_ferr, 0);
    check("up_overflow", int'(overflow), 0);

    // Typematic repeats, release, press again: two events.
    exp_q.push_back(2'd2);
    repeat (3) begin send(8'hE0); send(8'h6B); end
    send(8'hE0); send(8'hF0); send(8'h6B);
    exp_q.push_back(2'd2);
    send(8'hE0); send(8'h6B);
    drain("left_drain");

    // Parity error then a good right arrow.
    send_byte(8'h75, 1'b1, 1'b1);
    check("par_err_cnt", n_perr, 1);
    exp_q.push_back(2'd3);
    send(8'hE0); send(8'h74);
    drain("right_drain");

    // Bad stop bit.
    ferr0 = n_ferr;
    send_byte(8'h72, 1'b0, 1'b0);
    check("stop_err_cnt", n_ferr - ferr0, 1);

    // Backpressure: first event held, second dropped.
    move_ready = 1'b0;
    exp_q.push_back(2'd0);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h72);
    check("bp_valid", int'(move_valid), 1);
    check("bp_dir", int'(move_dir), 0);
    check("bp_overflow", int'(overflow), 1);
    move_ready = 1'b1;
    drain("bp_drain");
    idle(2);
    check("bp_valid_fall", int'(move_valid), 0);
    check("overflow_sticky", int'(overflow), 1);

    // Release down, then timeout on a partial frame, then down again.
    send(8'hE0); send(8'hF0); send(8'h72);
    ferr0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    PS2_DAT = 1'b1;
    idle(TO_CYC + 50);
    check("timeout_err_cnt", n_ferr - ferr0, 1);
    exp_q.push_back(2'd1);
    send(8'hE0); send(8'h72);
    drain("down_drain");

    // Reset mid-frame.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    PS2_DAT = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(3);
    check("midrst_valid", int'(move_valid), 0);
    check("midrst_overflow", int'(overflow), 0);
    reset = 1'b0;
    idle(5);
    perr0 = n_perr;
    ferr0 = n_ferr;
    exp_q.push_back(2'd2);
    send(8'hE0); send(8'h6B);
    drain("postrst_drain");
    check("postrst_errs", (n_perr - perr0) + (n_ferr - ferr0), 0);

    // Unprefixed W.
`ifdef PS2_ARROW_WASD_EN
    exp_q.push_back(2'd0);
`endif
    send(8'h1D);
    idle(40);
    drain("wasd_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
